// File: rtl/style_match_pkg.sv
// Shared widths, config addresses and the per-lane style record
// for the style_match_pipe slice.
package style_match_pkg;

  localparam int CLASS_W   = 6;
  localparam int STYLE_W   = 6;
  localparam int DISPLAY_W = 5;

  localparam int CFG_PRIM     = 0;
  localparam int CFG_NOPSEUDO = 1;
  localparam int CFG_DISP0    = 2;

  typedef struct packed {
    logic                 elem_valid;
    logic                 is_svg;
    logic [STYLE_W-1:0]   style_type;
    logic [DISPLAY_W-1:0] display;
    logic [CLASS_W-1:0]   class_type;
  } lane_rec_t;

endpackage

// File: rtl/style_lane_cmp.sv
// Single-lane combinational evaluator: primitive-class match and
// valid-display-value match against the programmed reference codes.
module style_lane_cmp
  import style_match_pkg::*;
#(
  parameter int NUM_DISP = 3
) (
  input  lane_rec_t                     rec,
  input  logic [CLASS_W-1:0]            prim_cls,
  input  logic [STYLE_W-1:0]            nopseudo,
  input  logic [NUM_DISP*DISPLAY_W-1:0] slot_code,
  input  logic [NUM_DISP-1:0]           slot_en,
  output logic                          is_prim,
  output logic                          is_disp
);

  logic [NUM_DISP-1:0] slot_hit;

  generate
    for (genvar gi = 0; gi < NUM_DISP; gi++) begin : g_slot
      assign slot_hit[gi] = slot_en[gi] &&
                            (slot_code[gi*DISPLAY_W +: DISPLAY_W] == rec.display);
    end
  endgenerate

  assign is_prim = (rec.class_type == prim_cls);
  // A disabled slot can never hit, so all-disabled forces is_disp low.
  assign is_disp = rec.elem_valid && rec.is_svg &&
                   (rec.style_type == nopseudo) && (|slot_hit);

endmodule

// File: rtl/style_match_pipe.sv
// Two-stage, multi-lane style comparator with programmable reference codes
// and a saturating display-match counter.
module style_match_pipe
  import style_match_pkg::*;
#(
  parameter int LANES    = 4,
  parameter int NUM_DISP = 3,
  parameter int COUNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_DISP+2)-1:0] cfg_addr,
  input  logic [5:0]                    cfg_wdata,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0]              in_elem_valid,
  input  logic [LANES-1:0]              in_is_svg,
  input  logic [6*LANES-1:0]            in_style_type,
  input  logic [5*LANES-1:0]            in_display,
  input  logic [6*LANES-1:0]            in_class_type,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0]              out_is_prim,
  output logic [LANES-1:0]              out_is_disp,
  input  logic                          cnt_clr,
  output logic [COUNT_W-1:0]            match_cnt
);

  localparam int ADDR_W = $clog2(NUM_DISP+2);
  localparam int SUM_W  = COUNT_W + $clog2(LANES+1) + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  logic [CLASS_W-1:0]            prim_cls_reg;
  logic [STYLE_W-1:0]            nopseudo_reg;
  logic [NUM_DISP*DISPLAY_W-1:0] slot_code_reg;
  logic [NUM_DISP-1:0]           slot_en_reg;

  lane_rec_t        in_rec     [LANES];
  lane_rec_t        s1_rec_reg [LANES];
  logic             s1_valid_reg;
  logic             s2_valid_reg;
  logic [LANES-1:0] s2_prim_reg;
  logic [LANES-1:0] s2_disp_reg;
  logic [LANES-1:0] eval_prim;
  logic [LANES-1:0] eval_disp;
  logic             advance;

  logic [SUM_W-1:0]   disp_pop;
  logic [SUM_W-1:0]   cnt_sum;
  logic [COUNT_W-1:0] match_cnt_reg;
  logic [COUNT_W-1:0] match_cnt_next;

  // Addresses beyond the last display slot match no branch and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prim_cls_reg  <= '0;
      nopseudo_reg  <= '0;
      slot_code_reg <= '0;
      slot_en_reg   <= '0;
    end else if (cfg_we) begin
      if (cfg_addr == ADDR_W'(CFG_PRIM))
        prim_cls_reg <= cfg_wdata[CLASS_W-1:0];
      if (cfg_addr == ADDR_W'(CFG_NOPSEUDO))
        nopseudo_reg <= cfg_wdata[STYLE_W-1:0];
      for (int k = 0; k < NUM_DISP; k++) begin
        if (cfg_addr == ADDR_W'(CFG_DISP0 + k)) begin
          slot_code_reg[k*DISPLAY_W +: DISPLAY_W] <= cfg_wdata[DISPLAY_W-1:0];
          slot_en_reg[k]                          <= cfg_wdata[5];
        end
      end
    end
  end

  assign advance  = !s2_valid_reg || out_ready;
  assign in_ready = advance;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign in_rec[gi] = {in_elem_valid[gi], in_is_svg[gi],
                           in_style_type[gi*6 +: 6], in_display[gi*5 +: 5],
                           in_class_type[gi*6 +: 6]};

      style_lane_cmp #(.NUM_DISP(NUM_DISP)) u_cmp (
        .rec       (s1_rec_reg[gi]),
        .prim_cls  (prim_cls_reg),
        .nopseudo  (nopseudo_reg),
        .slot_code (slot_code_reg),
        .slot_en   (slot_en_reg),
        .is_prim   (eval_prim[gi]),
        .is_disp   (eval_disp[gi])
      );
    end
  endgenerate

  // Both stages move together; a stalled S2 freezes S1 as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_prim_reg  <= '0;
      s2_disp_reg  <= '0;
      for (int i = 0; i < LANES; i++) s1_rec_reg[i] <= '0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
      s2_prim_reg  <= eval_prim;
      s2_disp_reg  <= eval_disp;
      s1_valid_reg <= in_valid && in_ready;
      for (int i = 0; i < LANES; i++) s1_rec_reg[i] <= in_rec[i];
    end
  end

  always_comb begin
    disp_pop = '0;
    for (int i = 0; i < LANES; i++) disp_pop = disp_pop + SUM_W'(s2_disp_reg[i]);
    cnt_sum        = SUM_W'(match_cnt_reg) + disp_pop;
    match_cnt_next = (cnt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[COUNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      match_cnt_reg <= '0;
    else if (cnt_clr)
      match_cnt_reg <= '0;
    else if (s2_valid_reg && out_ready)
      match_cnt_reg <= match_cnt_next;
  end

  assign out_valid   = s2_valid_reg;
  assign out_is_prim = s2_prim_reg;
  assign out_is_disp = s2_disp_reg;
  assign match_cnt   = match_cnt_reg;

endmodule
